// File: rtl/mod_mult_serial.sv
// mod_mult_serial: bit-serial (a * b) mod n, one multiplier bit per clock, MSB first.
// Interleaved shift-add; two conditional subtractions per step keep the accumulator below n.
module mod_mult_serial #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH+1:0] w_n_ext;
  logic [WIDTH+1:0] w_addend;
  logic [WIDTH+1:0] w_t0;
  logic [WIDTH+1:0] w_t1;
  logic [WIDTH-1:0] w_next;
  logic             w_bad_op;

  // r < n and b < n bound t below 3n, so WIDTH+2 bits and two subtractions suffice
  assign w_n_ext  = {2'b00, r_n};
  assign w_addend = r_a[r_idx] ? {2'b00, r_b} : '0;
  assign w_t0     = {1'b0, r_acc, 1'b0} + w_addend;
  assign w_t1     = (w_t0 >= w_n_ext) ? (w_t0 - w_n_ext) : w_t0;
  assign w_next   = (w_t1 >= w_n_ext) ? WIDTH'(w_t1 - w_n_ext) : w_t1[WIDTH-1:0];

  assign w_bad_op = (n == '0) || (b >= n);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_n   <= n;
            r_err <= 1'b0;
            if (w_bad_op) begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= '0;
              r_idx   <= LAST_IDX;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_next;
          if (r_idx == '0) begin
            r_result <= w_next;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_mod_mult_serial.sv
// Directed bench for mod_mult_serial at WIDTH = 128 with hand-computed products and latencies.
module tb_mod_mult_serial;

  localparam int W = 128;
  localparam logic [W-1:0] NBIG = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int total;
  int bad;

  mod_mult_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One operation from an IDLE negedge; j counts negedges after the accepting edge (j=0 first).
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] tn, input logic [W-1:0] exp_res, input logic exp_err,
                       input int exp_lat, input int exp_busy, input int exp_ndone,
                       input int poke_at, input int rst_at);
    int lat;
    int nbusy;
    int ndone;
    int both;
    logic [W-1:0] res_at_done;
    lat = -1; nbusy = 0; ndone = 0; both = 0; res_at_done = '0;
    a = ta; b = tb_v; n = tn; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err_at_accept"}, W'(err), W'(exp_err));
    for (int j = 0; j <= W + 8; j++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (busy) both = 1;
        if (lat < 0) begin
          lat = j;
          res_at_done = result;
        end
      end
      if (j == poke_at) begin
        a = 128'd3; b = 128'd1; n = 128'd4; start = 1'b1;
      end
      if (j == poke_at + 1) start = 1'b0;
      if (j == rst_at) reset = 1'b1;
      if (j == rst_at + 1) begin
        chk({tag, "_rst_busy"}, W'(busy), '0);
        chk({tag, "_rst_done"}, W'(done), '0);
        chk({tag, "_rst_err"}, W'(err), '0);
        chk({tag, "_rst_result"}, result, '0);
        reset = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_latency"}, W'(lat), W'(exp_lat));
    chk({tag, "_busy_cycles"}, W'(nbusy), W'(exp_busy));
    chk({tag, "_done_pulses"}, W'(ndone), W'(exp_ndone));
    chk({tag, "_busy_and_done"}, W'(both), '0);
    if (exp_ndone > 0) chk({tag, "_result_at_done"}, res_at_done, exp_res);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_err"}, W'(err), W'(exp_err));
  endtask

  initial begin
    int d1;
    int d2;
    int ndone;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; n = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_err", W'(err), '0);
    chk("reset_result", result, '0);
    reset = 1'b0;
    @(negedge clk);

    // 7*5 mod 11 = 2, with an ignored start pulse 50 cycles into RUN
    do_op("small", 128'd7, 128'd5, 128'd11, 128'd2, 1'b0, W + 1, W, 1, 50, -10);
    do_op("max_sq", NBIG - 1, NBIG - 1, NBIG, 128'd1, 1'b0, W + 1, W, 1, -10, -10);
    do_op("max_a", {W{1'b1}}, 128'd1, NBIG, 128'd158, 1'b0, W + 1, W, 1, -10, -10);
    do_op("big_b", 128'd1, NBIG - 1, NBIG, NBIG - 1, 1'b0, W + 1, W, 1, -10, -10);
    do_op("n_zero", 128'd5, 128'd3, 128'd0, 128'd0, 1'b1, 1, 0, 1, -10, -10);
    do_op("b_eq_n", 128'd5, 128'd13, 128'd13, 128'd0, 1'b1, 1, 0, 1, -10, -10);
    do_op("after_err", 128'd3, 128'd4, 128'd5, 128'd2, 1'b0, W + 1, W, 1, -10, -10);
    // reset mid-RUN: busy seen for j=0..60, no done, result cleared
    do_op("mid_reset", 128'd7, 128'd5, 128'd11, 128'd0, 1'b0, -1, 61, 0, -10, 60);
    do_op("zero_a", 128'd0, 128'd9, 128'd10, 128'd0, 1'b0, W + 1, W, 1, -10, -10);

    // start held high: 6*7 mod 13 = 3, then 8*9 mod 13 = 7
    d1 = -1; d2 = -1; ndone = 0;
    a = 128'd6; b = 128'd7; n = 128'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 128'd8; b = 128'd9;
    for (int j = 0; j <= 2 * W + 12; j++) begin
      if (done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = j;
          chk("b2b_first_result", result, 128'd3);
        end else if (d2 < 0) begin
          d2 = j;
          chk("b2b_second_result", result, 128'd7);
        end
      end
      if (j == W + 5) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_first_latency", W'(d1), W'(W + 1));
    chk("b2b_spacing", W'(d2 - d1), W'(W + 2));
    chk("b2b_done_pulses", W'(ndone), 128'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
